// File: rtl/baby_mon_pkg.sv
// Shared definitions for the baby monitor alert path: channel ids, the
// scheduler FSM encoding and the round-robin successor helper.
package baby_mon_pkg;

  localparam int NUM_CH = 3;

  localparam logic [1:0] CH_HB     = 2'd0;
  localparam logic [1:0] CH_TEMP   = 2'd1;
  localparam logic [1:0] CH_MOTION = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Next channel in the rotation 0 -> 1 -> 2 -> 0. The unused code 3 maps to 0.
  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c == CH_MOTION) ? CH_HB : c + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter. The search starts at the channel after
// `last`, so the most recently granted channel has the lowest priority.
// Purely combinational.
module rr_arb3
  import baby_mon_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_id,
  output logic       any
);

  logic [1:0] c1;
  logic [1:0] c2;
  logic [1:0] c3;

  // Scan last+1, last+2, last+3 (mod 3) and grant the first requester.
  always_comb begin
    c1     = next_ch(last);
    c2     = next_ch(c1);
    c3     = next_ch(c2);
    any    = |req;
    gnt_id = CH_HB;
    if (req[c1])      gnt_id = c1;
    else if (req[c2]) gnt_id = c2;
    else if (req[c3]) gnt_id = c3;
  end

endmodule

// File: rtl/baby_alert_scheduler.sv
// Shares one alert transmit channel between the heartbeat, temperature and
// motion alert sources. Alerts are captured per channel, granted
// round-robin, presented on a valid/ready handshake and followed by a
// hold-off gap.
//
// Handshake: tx_valid/tx_data/tx_ch are registered and held stable while
// tx_valid=1; a transfer completes on a rising edge where tx_valid=1 and
// tx_ready=1. tx_ready while tx_valid=0 has no effect. An asserted reset
// withdraws tx_valid immediately.
module baby_alert_scheduler
  import baby_mon_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int HOLDOFF = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          alert_pulse,
  input  logic [NUM_CH*DATA_W-1:0]   alert_value,
  input  logic                       tx_ready,
  input  logic                       clear_overrun,
  output logic                       tx_valid,
  output logic [DATA_W-1:0]          tx_data,
  output logic [1:0]                 tx_ch,
  output logic [NUM_CH-1:0]          pending,
  output logic [NUM_CH-1:0]          overrun,
  output logic                       busy,
  output state_t                     state_dbg
);

  // Value reloaded into the hold counter; HOLDOFF=0 never enters HOLD.
  localparam logic [7:0] HOLD_INIT = 8'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

  state_t            state;
  state_t            state_next;
  logic [7:0]        cnt;
  logic [1:0]        last;
  logic [DATA_W-1:0] val_q [NUM_CH];

  logic [1:0]        gnt_id;
  logic              gnt_any;
  logic              grant_fire;
  logic              send_done;
  logic [NUM_CH-1:0] gnt_hit;
  logic [NUM_CH-1:0] ovr_evt;
  logic [DATA_W-1:0] gnt_val;

  rr_arb3 u_arb (
    .req    (pending),
    .last   (last),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  // Next-state logic plus the grant/accept strobes that drive the datapath.
  always_comb begin
    state_next = state;
    grant_fire = 1'b0;
    send_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_any) begin
          grant_fire = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          send_done  = 1'b1;
          state_next = (HOLDOFF == 0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (cnt == 8'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant decode, overrun detection and granted-value mux.
  always_comb begin
    gnt_hit = grant_fire ? (3'b001 << gnt_id) : 3'b000;
    // A pulse on an already-pending channel that is not being granted
    // this edge overwrites an unsent value.
    ovr_evt = alert_pulse & pending & ~gnt_hit;
    unique case (gnt_id)
      2'd1:    gnt_val = val_q[1];
      2'd2:    gnt_val = val_q[2];
      default: gnt_val = val_q[0];
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Per-channel capture: a pulse always wins over the grant clear, so a
  // re-pulse on the grant edge keeps the channel pending with its new value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      overrun <= '0;
      for (int i = 0; i < NUM_CH; i++) val_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (alert_pulse[i]) begin
          pending[i] <= 1'b1;
          val_q[i]   <= alert_value[i*DATA_W +: DATA_W];
        end else if (gnt_hit[i]) begin
          pending[i] <= 1'b0;
        end
      end
      overrun <= (clear_overrun ? '0 : overrun) | ovr_evt;
    end
  end

  // Transmit registers and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_ch    <= 2'd0;
      last     <= CH_MOTION;
    end else if (grant_fire) begin
      tx_valid <= 1'b1;
      tx_data  <= gnt_val;
      tx_ch    <= gnt_id;
      last     <= gnt_id;
    end else if (send_done) begin
      tx_valid <= 1'b0;
    end
  end

  // Hold-off counter: loaded on acceptance, counts down to 0 in HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           cnt <= 8'd0;
    else if (send_done)                   cnt <= HOLD_INIT;
    else if (state == HOLD && cnt != 8'd0) cnt <= cnt - 8'd1;
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_baby_alert_scheduler.sv
// Directed bench for baby_alert_scheduler: a HOLDOFF=4 instance checked by
// cycle-level expectations and a transfer scoreboard, plus a HOLDOFF=0
// instance for the back-to-back spacing.
module tb_baby_alert_scheduler;
  import baby_mon_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [2:0]   alert_pulse;
  logic [3*W-1:0] alert_value;
  logic         tx_ready;
  logic         clear_overrun;

  logic         tx_valid, busy;
  logic [W-1:0] tx_data;
  logic [1:0]   tx_ch;
  logic [2:0]   pending, overrun;
  state_t       state_dbg;

  logic         tx_valid0, busy0;
  logic [W-1:0] tx_data0;
  logic [1:0]   tx_ch0;
  logic [2:0]   pending0, overrun0;
  state_t       state_dbg0;

  baby_alert_scheduler #(.DATA_W(W), .HOLDOFF(4)) dut (
    .clk(clk), .reset(reset), .alert_pulse(alert_pulse), .alert_value(alert_value),
    .tx_ready(tx_ready), .clear_overrun(clear_overrun), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ch(tx_ch), .pending(pending), .overrun(overrun),
    .busy(busy), .state_dbg(state_dbg)
  );

  baby_alert_scheduler #(.DATA_W(W), .HOLDOFF(0)) dut0 (
    .clk(clk), .reset(reset), .alert_pulse(alert_pulse), .alert_value(alert_value),
    .tx_ready(tx_ready), .clear_overrun(clear_overrun), .tx_valid(tx_valid0),
    .tx_data(tx_data0), .tx_ch(tx_ch0), .pending(pending0), .overrun(overrun0),
    .busy(busy0), .state_dbg(state_dbg0)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard of {ch, data} transfers expected from the HOLDOFF=4 instance.
  logic [W+1:0] exp_q[$];

  always @(negedge clk) begin
    if (reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected", {22'd0, tx_ch, tx_data}, 32'hFFFF_FFFF);
      else check("sb_xfer", {22'd0, tx_ch, tx_data}, {22'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alert_pulse   = 3'b000;
    alert_value   = '0;
    clear_overrun = 1'b0;
    reset         = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Drive pulses for exactly one edge; values ordered {ch2, ch1, ch0}.
  task automatic pulse(input logic [2:0] mask, input logic [W-1:0] v0,
                       input logic [W-1:0] v1, input logic [W-1:0] v2);
    alert_pulse = mask;
    alert_value = {v2, v1, v0};
    tick();
    alert_pulse = 3'b000;
  endtask

  // Advance at least one edge until tx_valid of the chosen instance is 1.
  task automatic wait_valid(input bit use0, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(use0 ? tx_valid0 : tx_valid) && cyc < 40);
    if (!(use0 ? tx_valid0 : tx_valid)) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int cyc;

  initial begin
    reset = 1'b0;
    tx_ready = 1'b1;
    do_reset();

    // Reset state
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_tx_ch", {30'd0, tx_ch}, 32'd0);
    check("rst_pending", {29'd0, pending}, 32'd0);
    check("rst_overrun", {29'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);

    // Single alert: ch0 = 130
    tx_ready = 1'b1;
    exp_q.push_back({2'd0, 8'd130});
    pulse(3'b001, 8'd130, 8'd0, 8'd0);
    check("single_pending", {29'd0, pending}, 32'd1);
    check("single_not_yet", {31'd0, tx_valid}, 32'd0);
    tick();
    check("single_valid", {31'd0, tx_valid}, 32'd1);
    check("single_data", {24'd0, tx_data}, 32'd130);
    check("single_ch", {30'd0, tx_ch}, 32'd0);
    check("single_pend_clr", {29'd0, pending}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("single_hold", {30'd0, busy, tx_valid}, 32'd2);
    end
    tick();
    check("single_idle", {31'd0, busy}, 32'd0);
    check("single_idle_pend", {29'd0, pending}, 32'd0);

    // Round-robin: all three at once
    do_reset();
    exp_q.push_back({2'd0, 8'd80});
    exp_q.push_back({2'd1, 8'd110});
    exp_q.push_back({2'd2, 8'd1});
    pulse(3'b111, 8'd80, 8'd110, 8'd1);
    wait_valid(1'b0, cyc);
    check("rr_first_lat", cyc, 32'd1);
    check("rr_first", {22'd0, tx_ch, tx_data}, {22'd0, 2'd0, 8'd80});
    wait_valid(1'b0, cyc);
    check("rr_gap1", cyc, 32'd6);
    check("rr_second", {22'd0, tx_ch, tx_data}, {22'd0, 2'd1, 8'd110});
    wait_valid(1'b0, cyc);
    check("rr_gap2", cyc, 32'd6);
    check("rr_third", {22'd0, tx_ch, tx_data}, {22'd0, 2'd2, 8'd1});
    check("rr_overrun", {29'd0, overrun}, 32'd0);
    for (int i = 0; i < 6; i++) tick();

    // Backpressure on a ch1 alert of 110
    do_reset();
    tx_ready = 1'b0;
    exp_q.push_back({2'd1, 8'd110});
    pulse(3'b010, 8'd0, 8'd110, 8'd0);
    wait_valid(1'b0, cyc);
    check("bp_lat", cyc, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_stable", {21'd0, tx_valid, tx_ch, tx_data}, {21'd0, 1'b1, 2'd1, 8'd110});
    end
    tx_ready = 1'b1;
    tick();
    check("bp_accept", {31'd0, tx_valid}, 32'd0);
    for (int i = 0; i < 5; i++) tick();

    // Overrun on ch2 while ch0 is stalled in SEND
    do_reset();
    tx_ready = 1'b0;
    exp_q.push_back({2'd0, 8'd7});
    exp_q.push_back({2'd2, 8'd1});
    pulse(3'b001, 8'd7, 8'd0, 8'd0);
    tick();
    check("ovr_send", {31'd0, tx_valid}, 32'd1);
    pulse(3'b100, 8'd0, 8'd0, 8'd0);
    check("ovr_first_none", {29'd0, overrun}, 32'd0);
    pulse(3'b100, 8'd0, 8'd0, 8'd1);
    check("ovr_set", {29'd0, overrun}, 32'b100);
    check("ovr_pending", {29'd0, pending}, 32'b100);
    tx_ready = 1'b1;
    wait_valid(1'b0, cyc);
    check("ovr_gap", cyc, 32'd6);
    check("ovr_latest", {22'd0, tx_ch, tx_data}, {22'd0, 2'd2, 8'd1});
    check("ovr_sticky", {29'd0, overrun}, 32'b100);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("ovr_clear", {29'd0, overrun}, 32'd0);
    for (int i = 0; i < 6; i++) tick();

    // Same-edge re-pulse on ch0 at its grant
    do_reset();
    tx_ready = 1'b1;
    exp_q.push_back({2'd0, 8'd10});
    exp_q.push_back({2'd0, 8'd20});
    pulse(3'b001, 8'd10, 8'd0, 8'd0);
    pulse(3'b001, 8'd20, 8'd0, 8'd0);
    check("rep_grant", {22'd0, tx_ch, tx_data}, {22'd0, 2'd0, 8'd10});
    check("rep_pending", {29'd0, pending}, 32'd1);
    check("rep_overrun", {29'd0, overrun}, 32'd0);
    wait_valid(1'b0, cyc);
    check("rep_gap", cyc, 32'd6);
    check("rep_second", {22'd0, tx_ch, tx_data}, {22'd0, 2'd0, 8'd20});
    for (int i = 0; i < 6; i++) tick();

    // Reset asserted mid-SEND drops everything without a clock edge
    do_reset();
    tx_ready = 1'b0;
    pulse(3'b010, 8'd0, 8'd55, 8'd0);
    tick();
    check("mid_send_valid", {31'd0, tx_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_outs", {19'd0, tx_valid, busy, tx_ch, tx_data},
          32'd0);
    check("mid_rst_flags", {26'd0, pending, overrun}, 32'd0);
    check("mid_rst_valid0", {31'd0, tx_valid0}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // HOLDOFF=0: back-to-back alerts two cycles apart
    tx_ready = 1'b1;
    exp_q.push_back({2'd0, 8'd5});
    exp_q.push_back({2'd1, 8'd6});
    pulse(3'b011, 8'd5, 8'd6, 8'd0);
    wait_valid(1'b1, cyc);
    check("h0_first_lat", cyc, 32'd1);
    check("h0_first", {22'd0, tx_ch0, tx_data0}, {22'd0, 2'd0, 8'd5});
    wait_valid(1'b1, cyc);
    check("h0_gap", cyc, 32'd2);
    check("h0_second", {22'd0, tx_ch0, tx_data0}, {22'd0, 2'd1, 8'd6});
    tick();
    check("h0_idle", {30'd0, busy0, tx_valid0}, 32'd0);
    for (int i = 0; i < 12; i++) tick();

    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/baby_alert_scheduler.md
Name: baby_alert_scheduler

Overview:
- Shares one alert transmit channel (buzzer/display/UART front-end) between the three monitor alert sources: heartbeat (ch0), temperature (ch1) and motion (ch2).
- Captures per-channel alert events with their 8-bit values and grants the channel round-robin.
- Presents each alert on a valid/ready handshake, then enforces a hold-off gap before the next alert.
- Sits between the baby monitoring datapath's alert outputs and the notification sink.

Parameters:
- DATA_W, 8, width of each alert value and of tx_data.
- HOLDOFF, 16, idle cycles after each accepted alert before the next grant. Legal range 0..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. 0 = reset asserted.
- alert_pulse  in  3  one-cycle alert event per channel. Bit0 = heartbeat, bit1 = temperature, bit2 = motion.
- alert_value  in  3*DATA_W  per-channel value. Slice i = [i*DATA_W +: DATA_W]. Sampled when alert_pulse[i]=1.
- tx_ready  in  1  sink accepts the current alert.
- clear_overrun  in  1  synchronous clear of all overrun bits.
- tx_valid  out  1  alert presented to the sink.
- tx_data  out  DATA_W  value of the granted alert.
- tx_ch  out  2  granted channel id (0..2).
- pending  out  3  per-channel alert waiting for a grant.
- overrun  out  3  sticky: an un-sent alert was overwritten.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, reset=0): state=IDLE; tx_valid=0, tx_data=0, tx_ch=0, pending=0, overrun=0, busy=0; hold counter=0; rr pointer last=2, so ch0 has first priority.
- Capture: on a clock edge with alert_pulse[i]=1, pending[i]<=1 and val_q[i]<=slice i. A later pulse overwrites val_q[i].
- Overrun: if pending[i] is already 1 and not being granted on that edge, overrun[i]<=1.
- clear_overrun clears all overrun bits. A new overrun event on the same edge wins.
- FSM states: IDLE, SEND, HOLD. busy=1 in SEND and HOLD.
- IDLE: if pending!=0, grant the first set bit scanning last+1, last+2, last+3 (mod 3).
  - Registered outputs on that edge: tx_valid<=1, tx_data<=val_q[g], tx_ch<=g; last<=g; pending[g]<=0; state<=SEND.
  - If alert_pulse[g] is also 1 on that edge, pending[g] stays 1 with the new value and overrun is not set.
- SEND: tx_valid, tx_data and tx_ch are held stable until an edge with tx_ready=1.
  - On that edge: tx_valid<=0.
  - If HOLDOFF=0: state<=IDLE.
  - Otherwise: counter<=HOLDOFF-1 and state<=HOLD.
  - tx_ready with tx_valid=0 is ignored.
- HOLD: counter decrements each cycle. When counter==0, state<=IDLE. Gives exactly HOLDOFF cycles with tx_valid=0.
- Pulses are captured in every state. Alerts are never lost; they are coalesced with overrun flagged.
- Latency: pulse captured at edge N, state IDLE -> tx_valid=1 after edge N+1. Back-to-back alerts with tx_ready tied 1 -> one alert per HOLDOFF+2 cycles.
- No combinational path from inputs to outputs. All outputs are registered.
- Reset asserted in SEND or HOLD aborts the transfer immediately (tx_valid drops asynchronously). The sink must tolerate this.

Decomposition:
- Shared package baby_mon_pkg holds:
  - Channel ids CH_HB=0, CH_TEMP=1, CH_MOTION=2, and NUM_CH=3.
  - State encoding IDLE=2'd0, SEND=2'd1, HOLD=2'd2.
- One sub-module: rr_arb3. It is combinational: inputs req[2:0] and last[1:0]; outputs gnt_id[1:0] and any.
- Capture registers, FSM and counter stay in the top module.

Test Plan (HOLDOFF=4 unless stated):
- Single alert: ch0 pulse, value 130, tx_ready=1 -> tx_valid one cycle after capture with tx_data=130, tx_ch=0; then busy for 4 HOLD cycles; then IDLE, pending=0.
- Round-robin: pulses on all channels in one cycle (80, 110, 1), tx_ready=1 -> order ch0, ch1, ch2 with 4-cycle gaps; overrun=0.
- Backpressure: tx_ready=0 for 10 cycles after a ch1 alert of 110 -> tx_valid, tx_data and tx_ch stay stable; acceptance only on the first edge with tx_ready=1.
- Overrun: two ch2 pulses (0 then 1) while in SEND -> overrun=3'b100; later tx_data=1; clear_overrun -> overrun=0.
- Same-edge re-pulse: ch0 pulse coincident with ch0 grant -> pending[0] stays 1 with the new value; overrun[0] stays 0; sent again after hold-off.
- Reset mid-SEND plus HOLDOFF=0 build: assert reset in SEND -> all outputs 0 immediately. With HOLDOFF=0, back-to-back alerts are 2 cycles apart.
